// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder controller driving one shared narrow adder.
// Adds NUM_WORDS words least-significant first, carrying between words.
module wide_add_sequencer #(
   parameter int BIT_WIDTH = 4,
   parameter int NUM_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [BIT_WIDTH*NUM_WORDS-1:0] a_in,
   input  logic [BIT_WIDTH*NUM_WORDS-1:0] b_in,
   input  logic                           carry_in,
   output logic [BIT_WIDTH-1:0]           add_a,
   output logic [BIT_WIDTH-1:0]           add_b,
   output logic                           add_cin,
   input  logic [BIT_WIDTH-1:0]           add_sum,
   input  logic                           add_cout,
   output logic                           busy,
   output logic                           done,
   output logic [BIT_WIDTH*NUM_WORDS-1:0] sum_out,
   output logic                           overflow
);

   localparam int W  = BIT_WIDTH * NUM_WORDS;
   localparam int IW = $clog2(NUM_WORDS + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  a_q, b_q, sum_q;
   logic          carry_q, ovf_q;
   logic          accept;
   logic          in_add;
   logic          last;

   assign in_add = (state_q == S_ADD);
   assign last   = (idx_q == LAST);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            add_a   = a_q[idx_q*BIT_WIDTH +: BIT_WIDTH];
            add_b   = b_q[idx_q*BIT_WIDTH +: BIT_WIDTH];
            add_cin = carry_q;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            accept  = start;
            state_d = start ? S_ADD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         a_q     <= a_in;
         b_q     <= b_in;
         carry_q <= carry_in;
      end else if (in_add) begin
         sum_q[idx_q*BIT_WIDTH +: BIT_WIDTH] <= add_sum;
         carry_q <= add_cout;
         // index parks at NUM_WORDS after the last word; next accept clears it
         idx_q   <= idx_q + IW'(1);
         if (last) ovf_q <= add_cout;
      end
   end

   assign busy     = in_add;
   assign done     = (state_q == S_DONE);
   assign sum_out  = sum_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a behavioural narrow adder.
// Vector table plus hand-written ignore/reset/back-to-back sequences.
module tb_wide_add_sequencer;

   localparam int BW = 4;
   localparam int NW = 4;
   localparam int W  = BW * NW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a_in, b_in;
   logic          carry_in;
   logic [BW-1:0] add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          busy, done, overflow;
   logic [W-1:0]  sum_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   wide_add_sequencer #(.BIT_WIDTH(BW), .NUM_WORDS(NW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .carry_in (carry_in),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .overflow (overflow)
   );

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          cin;
      logic [W-1:0]  a_seq;
      logic [W-1:0]  b_seq;
      logic [NW-1:0] cin_seq;
      logic [W-1:0]  sum;
      logic          ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [W-1:0] as, bs;
      as = v.a_seq;
      bs = v.b_seq;
      start = 1'b1;
      a_in = v.a;
      b_in = v.b;
      carry_in = v.cin;
      step();
      start = 1'b0;
      a_in = '0;
      b_in = '0;
      carry_in = 1'b0;
      for (int i = 0; i < NW; i++) begin
         chk("busy", 32'(busy), 32'd1);
         chk("done_early", 32'(done), 32'd0);
         chk("add_a", 32'(add_a), 32'(as[i*BW +: BW]));
         chk("add_b", 32'(add_b), 32'(bs[i*BW +: BW]));
         chk("add_cin", 32'(add_cin), 32'(v.cin_seq[i]));
         step();
      end
      chk("done", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("sum_out", 32'(sum_out), 32'(v.sum));
      chk("overflow", 32'(overflow), 32'(v.ovf));
      chk("add_a_idle", 32'(add_a), 32'd0);
      step();
      chk("done_once", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("sum_hold", 32'(sum_out), 32'(v.sum));
   endtask

   initial begin
      // word sequences are the operand nibbles, least-significant first
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h1234, 16'h4321,
                  4'b0000, 16'h5555, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0001,
                  4'b1110, 16'h0000, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000,
                  4'b1111, 16'h0000, 1'b1};
      vecs[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF,
                  4'b0000, 16'hFFFF, 1'b0};
      vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h0F0F, 16'h00F1,
                  4'b1110, 16'h1000, 1'b0};
      vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hABCD, 16'h1111,
                  4'b0001, 16'hBCDF, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      a_in = '0;
      b_in = '0;
      carry_in = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // start during busy is ignored
      start = 1'b1;
      a_in = 16'h1234;
      b_in = 16'h4321;
      carry_in = 1'b0;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      a_in = 16'hAAAA;
      b_in = 16'h5555;
      carry_in = 1'b1;
      step();
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      chk("ign_add_a", 32'(add_a), 32'h2);
      chk("ign_add_b", 32'(add_b), 32'h3);
      step();
      chk("ign_add_a3", 32'(add_a), 32'h1);
      chk("ign_done_early", 32'(done), 32'd0);
      step();
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_sum", 32'(sum_out), 32'h5555);
      chk("ign_ovf", 32'(overflow), 32'd0);
      step();
      chk("ign_done_once", 32'(done), 32'd0);
      chk("ign_idle", 32'(busy), 32'd0);

      // reset in the third ADD cycle aborts without a done pulse
      start = 1'b1;
      a_in = 16'hFFFF;
      b_in = 16'h0001;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_sum", 32'(sum_out), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      #4;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end
      run_vec(vecs[3]);

      // start held high across DONE: back-to-back operations
      start = 1'b1;
      a_in = 16'h1234;
      b_in = 16'h4321;
      carry_in = 1'b0;
      step();
      for (int c = 1; c <= 10; c++) begin
         chk("b2b_done", 32'(done), 32'((c == 5) || (c == 10)));
         chk("b2b_busy", 32'(busy), 32'((c != 5) && (c != 10)));
         if (c == 5) begin
            chk("b2b_sum1", 32'(sum_out), 32'h5555);
            a_in = 16'h0F0F;
            b_in = 16'h00F1;
         end
         if (c == 6) start = 1'b0;
         if (c == 10) begin
            chk("b2b_sum2", 32'(sum_out), 32'h1000);
            chk("b2b_ovf2", 32'(overflow), 32'd0);
         end
         step();
      end
      chk("b2b_end", 32'(done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
